// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - RV32I OP/OP-IMM decode and single-slot ALU issue/response control
// Optional perf counters built when ALU_PERF_CNT_EN is defined.
module alu_issue_ctrl #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [3:0]       alu_opcode,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_zero,
    output logic             out_illegal,
    output logic [4:0]       out_rd,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] perf_ops,
    output logic [CNT_W-1:0] perf_illegal
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;
    localparam logic [3:0] OP_NOP = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic             ill_q, ill_d;
    logic [4:0]       rd_q, rd_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      res_q, res_d;
    logic             zero_q, zero_d;

    logic        is_op, is_imm, f7_zero, f7_alt;
    logic [2:0]  f3;
    logic [3:0]  dec_op;
    logic [31:0] dec_b;
    logic        dec_ill;

    // rs1 index is resolved upstream; only its value arrives here.
    logic unused_rs1_idx;
    assign unused_rs1_idx = ^in_instr[19:15];

    always_comb begin
        is_op   = (in_instr[6:0] == 7'b0110011);
        is_imm  = (in_instr[6:0] == 7'b0010011);
        f3      = in_instr[14:12];
        f7_zero = (in_instr[31:25] == 7'b0000000);
        f7_alt  = (in_instr[31:25] == 7'b0100000);
        dec_op  = OP_NOP;
        dec_ill = 1'b0;

        if (is_op) begin
            dec_b = in_rs2;
        end else if (is_imm && (f3 == 3'b001 || f3 == 3'b101)) begin
            dec_b = {27'b0, in_instr[24:20]};
        end else begin
            dec_b = {{20{in_instr[31]}}, in_instr[31:20]};
        end

        // For OP-IMM non-shift ops, instr[31:25] is immediate, so funct7 is only checked for OP.
        case (f3)
            3'b000: begin
                if (is_op && f7_alt)        dec_op = OP_SUB;
                else if (is_op && !f7_zero) dec_ill = 1'b1;
                else                        dec_op = OP_ADD;
            end
            3'b001: begin
                dec_op  = OP_SLL;
                dec_ill = !f7_zero;
            end
            3'b010: begin
                dec_op  = OP_SLT;
                dec_ill = is_op && !f7_zero;
            end
            3'b011: dec_ill = 1'b1;
            3'b100: begin
                dec_op  = OP_XOR;
                dec_ill = is_op && !f7_zero;
            end
            3'b101: begin
                if (f7_zero)     dec_op = OP_SRL;
                else if (f7_alt) dec_op = OP_SRA;
                else             dec_ill = 1'b1;
            end
            3'b110: begin
                dec_op  = OP_OR;
                dec_ill = is_op && !f7_zero;
            end
            default: begin
                dec_op  = OP_AND;
                dec_ill = is_op && !f7_zero;
            end
        endcase

        if (!(is_op || is_imm)) dec_ill = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        ill_d   = ill_q;
        rd_d    = rd_q;
        tag_d   = tag_q;
        res_d   = res_q;
        zero_d  = zero_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_rs1;
                    b_d     = dec_b;
                    op_d    = dec_ill ? OP_NOP : dec_op;
                    ill_d   = dec_ill;
                    rd_d    = in_instr[11:7];
                    tag_d   = in_tag;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d   = ill_q ? 32'd0 : alu_result;
                zero_d  = ill_q ? 1'b0 : alu_zero;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= OP_NOP;
            ill_q   <= 1'b0;
            rd_q    <= 5'd0;
            tag_q   <= '0;
            res_q   <= 32'd0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            ill_q   <= ill_d;
            rd_q    <= rd_d;
            tag_q   <= tag_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_RESP);
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_opcode  = (state_q == S_EXEC) ? op_q : OP_NOP;
    assign out_result  = res_q;
    assign out_zero    = zero_q;
    assign out_illegal = ill_q;
    assign out_rd      = rd_q;
    assign out_tag     = tag_q;

`ifdef ALU_PERF_CNT_EN
    logic [CNT_W-1:0] perf_ops_q, perf_ops_d;
    logic [CNT_W-1:0] perf_ill_q, perf_ill_d;
    logic             resp_hs;

    always_comb begin
        resp_hs    = (state_q == S_RESP) && out_ready;
        perf_ops_d = perf_ops_q;
        perf_ill_d = perf_ill_q;
        if (resp_hs && !ill_q && perf_ops_q != {CNT_W{1'b1}}) perf_ops_d = perf_ops_q + 1'b1;
        if (resp_hs && ill_q && perf_ill_q != {CNT_W{1'b1}})  perf_ill_d = perf_ill_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops_q <= '0;
            perf_ill_q <= '0;
        end else begin
            perf_ops_q <= perf_ops_d;
            perf_ill_q <= perf_ill_d;
        end
    end

    assign perf_ops     = perf_ops_q;
    assign perf_illegal = perf_ill_q;
`else
    assign perf_ops     = '0;
    assign perf_illegal = '0;
`endif

endmodule
